// File: rtl/add_stream_pkg.sv
// Shared types, sizing helpers and the per-lane add/saturate function for add_stream.
package add_stream_pkg;

    // Widest lane the shared add function supports; lanes are zero-extended to this.
    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_W1 = MAX_W + 1;

    // Default configuration.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = $clog2(DEF_DEPTH + 1);

    // One FIFO entry at the default lane width.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 carry;
    } entry_t;

    // Adds two w-bit operands held in MAX_W-bit containers.
    // Returns {carry, sum}; carry sits at bit MAX_W, sum occupies bits [w-1:0].
    function automatic logic [MAX_W:0] lane_add(
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y,
        input int unsigned      w,
        input logic             sat_en
    );
        logic [MAX_W:0]   full;
        logic [MAX_W:0]   mask;
        logic             cout;
        logic [MAX_W-1:0] sum;
        full = {1'b0, x} + {1'b0, y};
        mask = (MAX_W1'(1) << w) - MAX_W1'(1);
        // Operands are below 2^w, so the only bit that can land above the mask is bit w.
        cout = |(full & ~mask);
        sum  = MAX_W'(full & mask);
        if (sat_en && cout) begin
            sum = MAX_W'(mask);
        end
        return {cout, sum};
    endfunction

endpackage

// File: rtl/add_stream_if.sv
// Bundles the add_stream handshake signals; reset lives inside the interface.
interface add_stream_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned DEPTH = 4
) (
    input logic clk
);
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*WIDTH-1:0]    a;
    logic [LANES*WIDTH-1:0]    b;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*WIDTH-1:0]    c;
    logic [LANES-1:0]          carry;
    logic [$clog2(DEPTH+1)-1:0] count;
endinterface

// File: rtl/add_stream_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO with ready/valid on both sides.
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
module add_stream_fifo
    import add_stream_pkg::*;
#(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              push;
    logic              pop;

    // Handshake flags derive from registered occupancy only; out_ready never reaches in_ready.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next pointer and occupancy state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next storage contents: write the incoming entry at the write pointer.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
    end

    // Pointer and occupancy registers; reset flushes all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/add_stream.sv
// Multi-lane registered adder with valid/ready handshakes and an output FIFO.
// Build option: define ADD_STREAM_SAT_EN to saturate overflowing lanes to all-ones
// (carry still reports 1); otherwise lane sums wrap modulo 2^WIDTH.
// WIDTH must not exceed add_stream_pkg::MAX_W.
module add_stream
    import add_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*WIDTH-1:0]     a,
    input  logic [LANES*WIDTH-1:0]     b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*WIDTH-1:0]     c,
    output logic [LANES-1:0]           carry,
    output logic [$clog2(DEPTH+1)-1:0] count
);
`ifdef ADD_STREAM_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam int unsigned SUM_W  = LANES * WIDTH;
    localparam int unsigned DATA_W = SUM_W + LANES;

    logic [SUM_W-1:0]  lane_sum;
    logic [LANES-1:0]  lane_carry;
    logic [DATA_W-1:0] fifo_out;

    // Independent lane adders; no carry passes between lanes.
    for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
        logic [MAX_W:0] res;
        logic           unused_res;

        // Per-lane add with optional saturation.
        always_comb begin
            res = lane_add(MAX_W'(a[k*WIDTH +: WIDTH]), MAX_W'(b[k*WIDTH +: WIDTH]),
                           WIDTH, SAT_EN);
        end

        assign lane_sum[k*WIDTH +: WIDTH] = res[WIDTH-1:0];
        assign lane_carry[k]              = res[MAX_W];
        assign unused_res                 = ^res;
    end

    add_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({lane_carry, lane_sum}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out),
        .count     (count)
    );

    assign c     = fifo_out[SUM_W-1:0];
    assign carry = fifo_out[DATA_W-1:SUM_W];

endmodule

// File: doc/add_stream.md
# add_stream

Parametrised, multi-lane, registered adder with valid/ready handshakes on both sides and an output FIFO. Per-lane sums of `a` and `b` are written into a DEPTH-entry buffer and drained under downstream back-pressure. It sits between a stimulus/producer stage and a consumer and supersedes the single-register adder with no flow control.

## Interface
Parameters:
- `WIDTH`, 8, bits per lane operand and result; must be ≥ 1.
- `LANES`, 1, independent adder channels packed side by side; must be ≥ 1.
- `DEPTH`, 4, output FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: producer presents `a`/`b`.
- `in_ready` output 1: block can accept; equals `count < DEPTH`.
- `a` input LANES*WIDTH: lane k operand is `a[k*WIDTH +: WIDTH]`.
- `b` input LANES*WIDTH: same packing as `a`.
- `out_valid` output 1: FIFO head holds a result.
- `out_ready` input 1: consumer takes the head.
- `c` output LANES*WIDTH: FIFO head sums, same packing as `a`.
- `carry` output LANES: per-lane carry-out of the head entry.
- `count` output $clog2(DEPTH+1): entries currently held.

## Operation
- Push happens when `in_valid && in_ready` at the rising edge. Each lane computes `{carry_k, sum_k} = a_k + b_k` as a WIDTH+1-bit sum, and the result is written at the write pointer.
- Pop happens when `out_valid && out_ready` at the rising edge. The read pointer advances.
- Push and pop in the same cycle: both occur and `count` is unchanged.
- When full, `in_ready` is 0 even if `out_ready` is 1. There is no combinational path from `out_ready` to `in_ready`.
- When empty, `out_valid` is 0. `c` and `carry` hold the last-written RAM value at the read pointer and are don't-care.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- Lanes never interact. There is no carry chaining between lanes.
- `count` is the only occupancy state. `out_valid = (count != 0)`.
- Input contents when `in_valid` is low are ignored.

## Timing
- Reset values (immediately on `rst` assertion): `count`=0, pointers=0, `out_valid`=0, `in_ready`=1. FIFO RAM is not reset; `c`/`carry` are don't-care until first push.
- Latency: data accepted at edge N is visible on `c`/`out_valid` after edge N, i.e. one cycle when empty.
- Throughput: one transfer per cycle per side when not full/empty.
- Reset mid-operation flushes all stored entries. In-flight handshakes that cycle are discarded.
- `out_valid`, `c`, `carry` and `in_ready` depend only on registered state.

## Configuration
- Macro `ADD_STREAM_SAT_EN`:
  - Defined: a lane whose carry-out is 1 stores all-ones (2^WIDTH−1) as its sum. `carry` still reports 1.
  - Undefined: sums wrap modulo 2^WIDTH.
- No other behaviour changes under the macro.

## Structure
- Package `add_stream_pkg` holds:
  - `function automatic` for the per-lane add/saturate, parametrised by width via a `localparam` in the caller.
  - Typedef of the FIFO-entry struct (`sum`, `carry`) for default width.
  - `localparam` for the count width helper.
- Sub-module `add_stream_fifo` is a generic DEPTH×entry synchronous FIFO with pointers, count and the ready/valid logic. The top level instantiates it and holds the lane adders.
- The bench connects through interface `add_stream_if #(WIDTH, LANES)` taking `clk` as a port. `rst` is internal to the interface.

## Test plan
- Reset then single push: WIDTH=8, LANES=1, a=3, b=4, out_ready=1. Required: c=7, carry=0, out_valid one cycle after accept, then count returns to 0.
- Overflow: a=200, b=100.
  - Macro undefined: c=44, carry=1.
  - Macro defined: c=255, carry=1.
- Fill and back-pressure: DEPTH=4, out_ready=0, push 5 vectors (i, i+1) for i=0..4. Required: in_ready drops after the 4th, count=4, and the 5th is not accepted. Release out_ready: results 1,3,5,7 come out in order.
- Simultaneous push/pop at count=2 for 6 cycles: count stays 2, order preserved, pointers wrap past 3 with no loss.
- LANES=4: a=0x01_FF_80_10, b=0x01_01_80_F0. Required: c=0x02_00_00_00, carry=4'b0111 (wrap mode).
- Reset asserted with count=3 mid-stream: immediately count=0, out_valid=0, in_ready=1. The next push returns only new data.
